// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Turns the timing generator's strobes and pixel coordinates into a 24-bit
// RGB test pattern (colour bars, checkerboard, gradient, bouncing box).
// The strobes travel through the same two register stages as the pixel data
// so the downstream encoder sees de/hs/vs aligned with RGB.
// Pattern selection and box motion are updated only on the rising edge of
// i_vs, so a frame is never drawn with a mix of patterns or box positions.

module video_pattern_gen #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_de,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [1:0] i_mode,
  output logic       o_de,
  output logic       o_hs,
  output logic       o_vs,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  // Bar width and the largest legal top-left corner of the box.
  localparam logic [9:0]  BAR_W   = 10'(WIDTH / 8);
  localparam logic [9:0]  BX_MAX  = 10'(WIDTH - BOX_SIZE);
  localparam logic [9:0]  BY_MAX  = 10'(HEIGHT - BOX_SIZE);
  localparam logic [10:0] BOX_LEN = 11'(BOX_SIZE);

  localparam logic [23:0] RGB_WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] RGB_BLACK = 24'h00_00_00;
  localparam logic [23:0] BOX_BG    = 24'h00_00_40;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_t;

  // Column to bar number; anything past the eighth bar is held at black.
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    logic [9:0] q;
    q = x / BAR_W;
    if (q > 10'd7) return 3'd7;
    return q[2:0];
  endfunction

  // Bar order white, yellow, cyan, green, magenta, red, blue, black:
  // red is on when bar bit1 is clear, green when bit2 is clear, blue when
  // bit0 is clear.
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    return {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  endfunction

  // One step of box motion along one axis; returns {negative_dir, position}.
  // Hitting either wall reverses direction and moves away in the same step,
  // so the position never leaves 0..lim.
  function automatic logic [10:0] box_step(input logic [9:0] pos,
                                           input logic       neg,
                                           input logic [9:0] lim);
    logic [10:0] nxt;
    if (!neg) begin
      if (pos >= lim) nxt = {1'b1, pos - 10'd1};
      else            nxt = {1'b0, pos + 10'd1};
    end else begin
      if (pos == 10'd0) nxt = {1'b0, 10'd1};
      else              nxt = {1'b1, pos - 10'd1};
    end
    return nxt;
  endfunction

  // Frame-rate control state.
  mode_t      mode_q;
  logic       vs_prev_q;
  logic [9:0] bx_q;
  logic [9:0] by_q;
  logic       dx_neg_q;
  logic       dy_neg_q;
  logic       frame_evt;

  // Stage-1 pattern terms (combinational, from the incoming pixel).
  logic [23:0] bar_rgb_s;
  logic        check_s;
  logic [23:0] grad_rgb_s;
  logic        in_box_s;
  logic [10:0] box_x_end;
  logic [10:0] box_y_end;

  // Stage-1 registers.
  logic        vld_p1;
  logic        hs_p1;
  logic        vs_p1;
  mode_t       mode_p1;
  logic [23:0] bar_rgb_p1;
  logic        check_p1;
  logic [23:0] grad_rgb_p1;
  logic        in_box_p1;

  // Stage-2 selection and registers.
  logic [23:0] rgb_sel;
  logic        vld_p2;
  logic        hs_p2;
  logic        vs_p2;
  logic [23:0] rgb_p2;

  assign frame_evt = i_vs & ~vs_prev_q;

  // Latch the requested mode and advance the box once per frame edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_prev_q <= 1'b0;
      mode_q    <= MODE_BARS;
      bx_q      <= 10'd0;
      by_q      <= 10'd0;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
    end else begin
      vs_prev_q <= i_vs;
      if (frame_evt) begin
        mode_q               <= mode_t'(i_mode);
        {dx_neg_q, bx_q}     <= box_step(bx_q, dx_neg_q, BX_MAX);
        {dy_neg_q, by_q}     <= box_step(by_q, dy_neg_q, BY_MAX);
      end
    end
  end

  // Evaluate every pattern term for the incoming pixel.
  always_comb begin
    box_x_end  = {1'b0, bx_q} + BOX_LEN;
    box_y_end  = {1'b0, by_q} + BOX_LEN;
    bar_rgb_s  = bar_colour(bar_index(i_x));
    check_s    = i_x[5] ^ i_y[5];
    grad_rgb_s = {i_x[7:0], i_y[7:0],
                  8'(({1'b0, i_x} + {1'b0, i_y}) >> 1)};
    in_box_s   = ({1'b0, i_x} >= {1'b0, bx_q}) && ({1'b0, i_x} < box_x_end) &&
                 ({1'b0, i_y} >= {1'b0, by_q}) && ({1'b0, i_y} < box_y_end);
  end

  // ---- stage 1: register strobes, the current mode and the pattern terms
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_p1      <= 1'b0;
      hs_p1       <= 1'b0;
      vs_p1       <= 1'b0;
      mode_p1     <= MODE_BARS;
      bar_rgb_p1  <= 24'h0;
      check_p1    <= 1'b0;
      grad_rgb_p1 <= 24'h0;
      in_box_p1   <= 1'b0;
    end else begin
      vld_p1      <= i_de;
      hs_p1       <= i_hs;
      vs_p1       <= i_vs;
      mode_p1     <= mode_q;
      bar_rgb_p1  <= bar_rgb_s;
      check_p1    <= check_s;
      grad_rgb_p1 <= grad_rgb_s;
      in_box_p1   <= in_box_s;
    end
  end

  // Pick the colour for the mode the pixel was captured under.
  always_comb begin
    rgb_sel = RGB_BLACK;
    case (mode_p1)
      MODE_BARS:  rgb_sel = bar_rgb_p1;
      MODE_CHECK: rgb_sel = check_p1 ? RGB_WHITE : RGB_BLACK;
      MODE_GRAD:  rgb_sel = grad_rgb_p1;
      MODE_BOX:   rgb_sel = in_box_p1 ? RGB_WHITE : BOX_BG;
      default:    rgb_sel = RGB_BLACK;
    endcase
  end

  // ---- stage 2: register RGB, blanked outside the active area
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      rgb_p2 <= 24'h0;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      rgb_p2 <= vld_p1 ? rgb_sel : 24'h0;
    end
  end

  assign o_de = vld_p2;
  assign o_hs = hs_p2;
  assign o_vs = vs_p2;
  assign o_r  = rgb_p2[23:16];
  assign o_g  = rgb_p2[15:8];
  assign o_b  = rgb_p2[7:0];

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a driver applies one pixel per clock and
// pushes the expected output into a queue using a frame-level reference
// model; a monitor pops one entry per clock and compares.
`timescale 1ns/1ps

module tb_video_pattern_gen;

  logic       clk;
  logic       rstn;
  logic       de, hs, vs;
  logic [9:0] x, y;
  logic [1:0] mode;
  logic       o_de, o_hs, o_vs;
  logic [7:0] o_r, o_g, o_b;

  video_pattern_gen dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_de  (de),
    .i_hs  (hs),
    .i_vs  (vs),
    .i_x   (x),
    .i_y   (y),
    .i_mode(mode),
    .o_de  (o_de),
    .o_hs  (o_hs),
    .o_vs  (o_vs),
    .o_r   (o_r),
    .o_g   (o_g),
    .o_b   (o_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   in_reset = 1'b1;

  // Reference model state, kept in plain integers.
  int m_mode, m_bx, m_by, m_dx, m_dy;
  bit m_vsprev;

  logic [23:0] bars_lut [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic void model_reset();
    m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_vsprev = 1'b0;
  endfunction

  function automatic void step_axis(inout int pos, inout int dir, input int lim);
    if (dir > 0) begin
      if (pos == lim) begin dir = -1; pos = pos - 1; end
      else pos = pos + 1;
    end else begin
      if (pos == 0) begin dir = 1; pos = 1; end
      else pos = pos - 1;
    end
  endfunction

  function automatic logic [23:0] model_rgb(input int px, input int py);
    int bar;
    logic [7:0] r, g, b;
    case (m_mode)
      0: begin
        bar = px / 80;
        if (bar > 7) bar = 7;
        return bars_lut[bar];
      end
      1: return (((px / 32) + (py / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      2: begin
        r = 8'(px % 256);
        g = 8'(py % 256);
        b = 8'(((px + py) / 2) % 256);
        return {r, g, b};
      end
      default: begin
        if (px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32)
          return 24'hFFFFFF;
        return 24'h000040;
      end
    endcase
  endfunction

  // Apply one pixel, record what should come out 2 clocks later, then
  // advance the model as the DUT will at the coming clock edge.
  task automatic drive(input logic d, input logic h, input logic v,
                       input int px, input int py, input int md);
    exp_t e;
    @(negedge clk);
    de = d; hs = h; vs = v; x = 10'(px); y = 10'(py); mode = 2'(md);
    e.de  = d;
    e.hs  = h;
    e.vs  = v;
    e.rgb = d ? model_rgb(px, py) : 24'h0;
    q.push_back(e);
    if (v && !m_vsprev) begin
      m_mode = md;
      step_axis(m_bx, m_dx, 608);
      step_axis(m_by, m_dy, 448);
    end
    m_vsprev = v;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({o_de, o_hs, o_vs, o_r, o_g, o_b} !== 27'd0) begin
      errors++;
      $display("FAIL %s: got de=%b hs=%b vs=%b rgb=%02h%02h%02h, expected all 0",
               tag, o_de, o_hs, o_vs, o_r, o_g, o_b);
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic reset_pulse(input int cycles);
    #3;
    rstn = 1'b0;
    in_reset = 1'b1;
    de = 0; hs = 0; vs = 0; x = 0; y = 0;
    q.delete();
    #1 check_zero("reset_async");
    repeat (cycles) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    in_reset = 1'b0;
  endtask

  // Monitor: one expected entry per clock once the pipeline is primed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset && q.size() >= 2) begin
        e = q.pop_front();
        checks++;
        if (o_de !== e.de || o_hs !== e.hs || o_vs !== e.vs ||
            {o_r, o_g, o_b} !== e.rgb) begin
          errors++;
          $display("FAIL pixel: got de=%b hs=%b vs=%b rgb=%02h%02h%02h, expected de=%b hs=%b vs=%b rgb=%06h",
                   o_de, o_hs, o_vs, o_r, o_g, o_b, e.de, e.hs, e.vs, e.rgb);
        end
      end
    end
  end

  initial begin
    int xs[4] = '{0, 80, 400, 639};
    logic rd, rh, rv;
    rstn = 1'b0;
    de = 0; hs = 0; vs = 0; x = 0; y = 0; mode = 0;
    model_reset();

    // Reset held, then released with every input at 0.
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    @(negedge clk);
    rstn = 1'b1;
    in_reset = 1'b0;
    repeat (6) drive(0, 0, 0, 0, 0, 0);

    // Colour bars across the line, including the last column.
    foreach (xs[i]) drive(1, 0, 0, xs[i], 5, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, i * 80 + 79, 7, 0);
    drive(1, 0, 0, 700, 7, 0);
    drive(0, 1, 0, 0, 0, 0);

    // Mode request mid-frame is ignored until the frame edge; the pixel on
    // the edge itself still uses bars.
    drive(1, 0, 0, 32, 0, 1);
    drive(1, 0, 0, 200, 32, 1);
    drive(1, 0, 1, 250, 0, 1);
    drive(1, 0, 1, 32, 0, 1);
    drive(1, 0, 1, 32, 32, 1);
    drive(1, 0, 0, 64, 96, 1);
    drive(0, 0, 0, 0, 0, 1);

    // Bouncing box: 608 frame edges take bx to the right wall, one more
    // reverses it.
    reset_pulse(2);
    for (int i = 0; i < 608; i++) begin
      drive(0, 0, 1, 0, 0, 3);
      drive(0, 0, 0, 0, 0, 3);
    end
    drive(1, 0, 0, 608, 288, 3);
    drive(1, 0, 0, 640, 288, 3);
    drive(1, 0, 0, 607, 288, 3);
    drive(1, 0, 0, 639, 319, 3);
    drive(1, 0, 0, 608, 320, 3);
    drive(0, 0, 1, 0, 0, 3);
    drive(0, 0, 0, 0, 0, 3);
    drive(1, 0, 0, 607, 287, 3);
    drive(1, 0, 0, 639, 287, 3);
    drive(1, 0, 0, 606, 287, 3);
    drive(1, 0, 0, 638, 318, 3);
    drive(1, 0, 0, 607, 319, 3);

    // Random strobe/pixel stream with random mode requests.
    rv = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rd = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rv = ~rv;
      drive(rd, rh, rv, int'($urandom_range(0, 799)), int'($urandom_range(0, 511)),
            int'($urandom_range(0, 3)));
    end
    drive(0, 0, 0, 0, 0, 2);

    // Gradient, then reset in the middle of a line.
    drive(0, 0, 1, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 2);
    drive(1, 0, 0, 300, 200, 2);
    drive(1, 0, 0, 511, 500, 2);
    drive(1, 1, 0, 100, 50, 2);
    reset_pulse(2);
    drive(1, 0, 0, 100, 10, 2);
    drive(1, 0, 0, 500, 10, 2);
    drive(1, 0, 0, 300, 10, 2);
    drive(0, 0, 1, 0, 0, 2);
    drive(1, 0, 1, 300, 200, 2);
    drive(1, 0, 0, 639, 479, 2);
    drive(0, 0, 0, 0, 0, 2);

    // Flush the pipeline; at most one primer entry may remain.
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() > 1) begin
      errors++;
      $display("FAIL drain: got %0d entries left, expected at most 1", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
